gshare_banked_predictor: RTL and testbench
==========================================

Name: gshare_banked_predictor

Overview:
Parametrised next-generation gshare conditional-branch direction predictor for the fetch unit. Supports configurable history length, including history longer than the PHT index, folded by XOR. Accepts multiple branch-resolution updates per cycle through a single-write-port PHT, with an ordered overflow queue and drop accounting. An explicit init state machine initialises the PHT and gates predictions until it finishes.

Parameters:
FETCH_WIDTH, 2, lookups (predictions) per cycle
UPD_WIDTH, 2, branch-resolution update ports per cycle
ADDR_BITS, 32, PC width
INSN_SHIFT, 2, low PC bits dropped before indexing
INDEX_BITS, 10, log2 of PHT entries
HIST_BITS, 12, global history length (1..3*INDEX_BITS)
CTR_BITS, 2, saturating counter width
QUEUE_DEPTH, 4, pending-update queue entries (power of 2)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
stall  in  1  fetch stall; freezes lookup address and history
lookup_pc  in  ADDR_BITS  PC of fetch slot 0; slot i uses lookup_pc + i*(1<<INSN_SHIFT)
btb_hit  in  FETCH_WIDTH  per slot, aligned with pred_* outputs
is_cond  in  FETCH_WIDTH  per slot conditional branch, aligned with pred_*
pred_taken  out  FETCH_WIDTH  predicted direction
pred_ctr  out  FETCH_WIDTH*CTR_BITS  counter read, for pipeline carry
pred_hist  out  HIST_BITS  history used for this prediction (recovery checkpoint)
upd_valid  in  UPD_WIDTH  resolved branch valid; port 0 is oldest
upd_pc  in  UPD_WIDTH*ADDR_BITS  branch PC
upd_hist  in  UPD_WIDTH*HIST_BITS  checkpointed history
upd_ctr  in  UPD_WIDTH*CTR_BITS  counter value at prediction
upd_taken  in  UPD_WIDTH  actual direction
upd_mispred  in  UPD_WIDTH  mispredicted
upd_is_cond  in  UPD_WIDTH  conditional branch
ready  out  1  init done
drop_cnt  out  16  updates discarded on queue overflow, saturating

Behaviour:
- Index: idx(pc,h) = pc[INDEX_BITS+INSN_SHIFT-1:INSN_SHIFT] XOR fold(h).
  - If HIST_BITS <= INDEX_BITS, fold(h) = h placed in the top HIST_BITS of the index.
  - Otherwise, fold(h) = XOR of consecutive INDEX_BITS chunks of h, LSB-aligned, last chunk zero-extended.
- Lookup, 1-cycle latency: the index uses next_hist in cycle t; the counter appears on pred_ctr in t+1.
  - pred_taken[i] = ctr MSB & btb_hit[i] & ready.
  - pred_hist = hist register in t+1.
- Stall: while stall=1, the read index is recomputed from held PC/hist values. Outputs stay stable and no prediction-driven history shift occurs.
- History (next_hist), when not stalled: start from hist. For slots i ascending with btb_hit & is_cond:
  - h = (h<<1) | pred_taken[i], truncated to HIST_BITS.
  - Stop after the first taken slot.
- Misprediction recovery overrides the prediction shift in the same cycle and also applies when stalled.
  - The lowest-index port with upd_valid & upd_mispred wins.
  - next_hist = upd_is_cond ? (upd_hist<<1)|upd_taken : upd_hist.
- Counter update: new = upd_taken ? min(upd_ctr+1, 2^CTR_BITS-1) : max(upd_ctr-1, 0). Index = idx(upd_pc, upd_hist). Counter is updated for every valid update, cond or not.
- Write arbitration: one PHT write per cycle, order preserved.
  - Queue non-empty: pop head to PHT; push all valid updates in port order.
  - Queue empty: lowest valid port writes directly; the rest are pushed.
  - Same-cycle pop and push are allowed; capacity is evaluated after the pop.
  - If free slots are insufficient, higher-index excess updates are dropped and drop_cnt += count dropped, saturating at 0xFFFF.
- Same-index read/write in one cycle: the read returns the old value; no bypass.
- Init FSM:
  - INIT: idx counter 0..2^INDEX_BITS-1; writes 2^(CTR_BITS-1) (weakly taken) one entry per cycle; ready=0; update inputs ignored and not queued.
  - INIT -> READY after the last index is written; ready=1 in the cycle after that write.
  - READY holds until rst.
- Reset (any time, including mid-INIT): FSM=INIT, idx=0, hist=0, queue empty, drop_cnt=0, ready=0.
  - Outputs after reset: pred_taken=0, pred_hist=0, pred_ctr=don't-care.
  - Init takes exactly 2^INDEX_BITS cycles after rst deasserts.

Test Plan:
- Init, INDEX_BITS=4: rst 1 cycle -> ready=0 for 16 cycles, ready=1 in cycle 17; every read returns ctr=2; pred_taken=1 when btb_hit=1.
- Training: 3 updates, pc=0x100, hist=0, taken=0 -> counter 2->1->0->0, saturating; lookup pc=0x100 with hist 0 -> pred_taken=0, pred_ctr=0.
- History shift: btb_hit=11, is_cond=11, predictions not-taken/taken from hist=0b101 -> hist=0b10101; with slot0 taken -> 0b1011, slot1 ignored.
- Recovery plus stall:
  - Stall with port1 mispred upd_hist=0x3, cond, taken=1 and port0 valid non-mispred -> hist=0x7 next cycle.
  - If port0 also mispreds, port0 wins.
- Overflow, QUEUE_DEPTH=2, UPD_WIDTH=2: 2 valid updates per cycle for 3 cycles -> PHT writes in port order; cycle 3 drops 1, drop_cnt=1; queue drains over next 2 cycles.
- Folding, HIST_BITS=12, INDEX_BITS=4: hist=0xABC, pc index 0 -> idx = 0xA^0xB^0xC = 0xD.

Source files
------------

// File: rtl/gshare_banked_predictor_if.sv
// gshare_banked_predictor_if: fetch-lookup and branch-resolution bundle for the gshare predictor.
//   master (fetch/commit side) drives stall, lookup_pc, btb_hit, is_cond and the upd_* group,
//   and receives pred_taken, pred_ctr, pred_hist, ready and drop_cnt.
//   slave (predictor) uses the same signals with the opposite directions.
interface gshare_banked_predictor_if #(
    parameter int FETCH_WIDTH = 2,
    parameter int UPD_WIDTH   = 2,
    parameter int ADDR_BITS   = 32,
    parameter int HIST_BITS   = 12,
    parameter int CTR_BITS    = 2
);
    logic                            stall;
    logic [ADDR_BITS-1:0]            lookup_pc;
    logic [FETCH_WIDTH-1:0]          btb_hit;
    logic [FETCH_WIDTH-1:0]          is_cond;
    logic [FETCH_WIDTH-1:0]          pred_taken;
    logic [FETCH_WIDTH*CTR_BITS-1:0] pred_ctr;
    logic [HIST_BITS-1:0]            pred_hist;
    logic [UPD_WIDTH-1:0]            upd_valid;
    logic [UPD_WIDTH*ADDR_BITS-1:0]  upd_pc;
    logic [UPD_WIDTH*HIST_BITS-1:0]  upd_hist;
    logic [UPD_WIDTH*CTR_BITS-1:0]   upd_ctr;
    logic [UPD_WIDTH-1:0]            upd_taken;
    logic [UPD_WIDTH-1:0]            upd_mispred;
    logic [UPD_WIDTH-1:0]            upd_is_cond;
    logic                            ready;
    logic [15:0]                     drop_cnt;

    modport master (
        output stall, lookup_pc, btb_hit, is_cond,
        output upd_valid, upd_pc, upd_hist, upd_ctr, upd_taken, upd_mispred, upd_is_cond,
        input  pred_taken, pred_ctr, pred_hist, ready, drop_cnt
    );

    modport slave (
        input  stall, lookup_pc, btb_hit, is_cond,
        input  upd_valid, upd_pc, upd_hist, upd_ctr, upd_taken, upd_mispred, upd_is_cond,
        output pred_taken, pred_ctr, pred_hist, ready, drop_cnt
    );
endinterface

// File: rtl/gshare_banked_predictor.sv
// gshare_banked_predictor: gshare direction predictor with folded history, multi-port
// updates funnelled through one PHT write port via an ordered overflow queue, and an
// init FSM that fills the PHT with weakly-taken counters before predictions are enabled.
//   clk, rst : clock and synchronous active-high reset
//   bus      : slave side of gshare_banked_predictor_if (lookup, prediction, update, status)
module gshare_banked_predictor #(
    parameter int FETCH_WIDTH = 2,
    parameter int UPD_WIDTH   = 2,
    parameter int ADDR_BITS   = 32,
    parameter int INSN_SHIFT  = 2,
    parameter int INDEX_BITS  = 10,
    parameter int HIST_BITS   = 12,
    parameter int CTR_BITS    = 2,
    parameter int QUEUE_DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    gshare_banked_predictor_if.slave bus
);
    localparam int ENTRIES = 1 << INDEX_BITS;
    localparam int QW      = $clog2(QUEUE_DEPTH);
    localparam int FSH     = HIST_BITS <= INDEX_BITS ? INDEX_BITS - HIST_BITS : 0;
    localparam logic [CTR_BITS-1:0] CTR_MAX  = '1;
    localparam logic [CTR_BITS-1:0] CTR_WEAK = CTR_BITS'(1) << (CTR_BITS - 1);

    typedef enum logic {S_INIT, S_READY} state_e;
    typedef struct packed {
        logic [INDEX_BITS-1:0] idx;
        logic [CTR_BITS-1:0]   ctr;
    } wr_t;

    // Short histories sit in the top index bits; long ones are XOR-folded in LSB-aligned chunks.
    function automatic logic [INDEX_BITS-1:0] fold(input logic [HIST_BITS-1:0] h);
        logic [INDEX_BITS-1:0] f;
        f = '0;
        if (HIST_BITS <= INDEX_BITS) f = INDEX_BITS'(h) << FSH;
        else for (int c = 0; c < HIST_BITS; c += INDEX_BITS) f ^= INDEX_BITS'(h >> c);
        return f;
    endfunction

    function automatic logic [INDEX_BITS-1:0] pht_idx(input logic [ADDR_BITS-1:0] pc,
                                                      input logic [HIST_BITS-1:0] h);
        return pc[INSN_SHIFT +: INDEX_BITS] ^ fold(h);
    endfunction

    function automatic logic [CTR_BITS-1:0] bump(input logic [CTR_BITS-1:0] c, input logic t);
        return t ? (c == CTR_MAX ? c : c + 1'b1) : (c == '0 ? c : c - 1'b1);
    endfunction

    state_e                          state_q, state_d;
    logic [INDEX_BITS-1:0]           init_q;
    logic [HIST_BITS-1:0]            hist_q, hist_d;
    logic [ADDR_BITS-1:0]            pc_q, look_pc;
    logic [CTR_BITS-1:0]             pht_q [ENTRIES];
    logic [FETCH_WIDTH*CTR_BITS-1:0] rd_q;
    logic [INDEX_BITS-1:0]           ridx [FETCH_WIDTH];
    wr_t                             q_q [QUEUE_DEPTH];
    wr_t                             q_d [QUEUE_DEPTH];
    logic [QW-1:0]                   head_q, head_d, tail;
    logic [QW:0]                     cnt_q, cnt_d;
    logic [15:0]                     drop_q, drop_d, ndrop;
    logic [16:0]                     dsum;
    logic                            ready, we, busy, stop, rec;
    wr_t                             wr;
    wr_t                             upd_w [UPD_WIDTH];
    logic [UPD_WIDTH-1:0]            uv;
    logic [FETCH_WIDTH-1:0]          taken;

    assign ready   = state_q == S_READY;
    // Updates are ignored entirely (no write, no queueing, no recovery) until init finishes.
    assign uv      = ready ? bus.upd_valid : '0;
    assign look_pc = bus.stall ? pc_q : bus.lookup_pc;

    for (genvar u = 0; u < UPD_WIDTH; u++) begin : g_upd
        assign upd_w[u] = '{idx: pht_idx(bus.upd_pc[u*ADDR_BITS +: ADDR_BITS],
                                         bus.upd_hist[u*HIST_BITS +: HIST_BITS]),
                            ctr: bump(bus.upd_ctr[u*CTR_BITS +: CTR_BITS], bus.upd_taken[u])};
    end

    for (genvar f = 0; f < FETCH_WIDTH; f++) begin : g_look
        assign ridx[f]  = pht_idx(look_pc + ADDR_BITS'(f << INSN_SHIFT), hist_d);
        assign taken[f] = rd_q[f*CTR_BITS + CTR_BITS - 1] & bus.btb_hit[f] & ready;
    end

    // Speculative shift up to the first predicted-taken slot; oldest mispredict overrides.
    always_comb begin
        hist_d = hist_q;
        stop   = 1'b0;
        rec    = 1'b0;
        for (int i = 0; i < FETCH_WIDTH; i++)
            if (!bus.stall && !stop && bus.btb_hit[i] && bus.is_cond[i]) begin
                hist_d = HIST_BITS'({hist_d, taken[i]});
                stop   = taken[i];
            end
        for (int i = 0; i < UPD_WIDTH; i++)
            if (!rec && uv[i] && bus.upd_mispred[i]) begin
                hist_d = bus.upd_is_cond[i]
                       ? HIST_BITS'({bus.upd_hist[i*HIST_BITS +: HIST_BITS], bus.upd_taken[i]})
                       : bus.upd_hist[i*HIST_BITS +: HIST_BITS];
                rec    = 1'b1;
            end
    end

    // Single PHT write port: init fill, else queue head, else oldest valid update.
    // Capacity for pushes is counted after this cycle's pop.
    always_comb begin
        state_d = state_q;
        q_d     = q_q;
        head_d  = head_q;
        cnt_d   = cnt_q;
        tail    = '0;
        we      = 1'b0;
        wr      = '0;
        busy    = 1'b0;
        ndrop   = '0;
        if (!ready) begin
            we = 1'b1;
            wr = '{idx: init_q, ctr: CTR_WEAK};
            if (init_q == INDEX_BITS'(ENTRIES - 1)) state_d = S_READY;
        end else if (cnt_q != '0) begin
            we     = 1'b1;
            wr     = q_q[head_q];
            head_d = head_q + 1'b1;
            cnt_d  = cnt_q - 1'b1;
            busy   = 1'b1;
        end
        for (int i = 0; i < UPD_WIDTH; i++)
            if (uv[i]) begin
                if (!busy) begin
                    we   = 1'b1;
                    wr   = upd_w[i];
                    busy = 1'b1;
                end else if (cnt_d < (QW + 1)'(QUEUE_DEPTH)) begin
                    tail      = head_d + QW'(cnt_d);
                    q_d[tail] = upd_w[i];
                    cnt_d     = cnt_d + 1'b1;
                end else ndrop = ndrop + 1'b1;
            end
        dsum   = {1'b0, drop_q} + {1'b0, ndrop};
        drop_d = dsum[16] ? 16'hFFFF : dsum[15:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_INIT;
            init_q  <= '0;
            hist_q  <= '0;
            pc_q    <= '0;
            head_q  <= '0;
            cnt_q   <= '0;
            drop_q  <= '0;
        end else begin
            state_q <= state_d;
            init_q  <= ready ? init_q : init_q + 1'b1;
            hist_q  <= hist_d;
            pc_q    <= look_pc;
            head_q  <= head_d;
            cnt_q   <= cnt_d;
            drop_q  <= drop_d;
        end
    end

    // Storage without reset; a same-index read in the write cycle returns the old value.
    always_ff @(posedge clk) begin
        if (we && !rst) pht_q[wr.idx] <= wr.ctr;
        q_q <= q_d;
        for (int i = 0; i < FETCH_WIDTH; i++) rd_q[i*CTR_BITS +: CTR_BITS] <= pht_q[ridx[i]];
    end

    assign bus.pred_taken = taken;
    assign bus.pred_ctr   = rd_q;
    assign bus.pred_hist  = hist_q;
    assign bus.ready      = ready;
    assign bus.drop_cnt   = drop_q;
endmodule

// File: tb/tb_gshare_banked_predictor.sv
// tb_gshare_banked_predictor: directed checks of init, training, history shift,
// recovery under stall, queue overflow/ordering, history folding and reset.
module tb_gshare_banked_predictor;
    localparam int FW = 2, UW = 2, AB = 32, SH = 2, IB = 4, HB = 12, CB = 2, QD = 2;

    logic clk = 1'b0;
    logic rst;
    int   n_chk = 0;
    int   n_fail = 0;
    int   n;

    always #5 clk = ~clk;

    gshare_banked_predictor_if #(.FETCH_WIDTH(FW), .UPD_WIDTH(UW), .ADDR_BITS(AB),
                                 .HIST_BITS(HB), .CTR_BITS(CB)) pif ();

    gshare_banked_predictor #(.FETCH_WIDTH(FW), .UPD_WIDTH(UW), .ADDR_BITS(AB),
                              .INSN_SHIFT(SH), .INDEX_BITS(IB), .HIST_BITS(HB),
                              .CTR_BITS(CB), .QUEUE_DEPTH(QD)) dut (
        .clk(clk),
        .rst(rst),
        .bus(pif)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_upd();
        pif.upd_valid   = '0;
        pif.upd_mispred = '0;
        pif.upd_is_cond = '0;
        pif.upd_taken   = '0;
    endtask

    task automatic set_upd(input int p, input logic [AB-1:0] pc, input logic [HB-1:0] h,
                           input logic [CB-1:0] c, input logic t, input logic m, input logic ic);
        pif.upd_valid[p]          = 1'b1;
        pif.upd_pc[p*AB +: AB]    = pc;
        pif.upd_hist[p*HB +: HB]  = h;
        pif.upd_ctr[p*CB +: CB]   = c;
        pif.upd_taken[p]          = t;
        pif.upd_mispred[p]        = m;
        pif.upd_is_cond[p]        = ic;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        pif.stall = 1'b0;
        pif.lookup_pc = '0;
        pif.btb_hit = '0;
        pif.is_cond = '0;
        pif.upd_pc = '0;
        pif.upd_hist = '0;
        pif.upd_ctr = '0;
        clr_upd();
        step();
        rst = 1'b0;
        pif.btb_hit = 2'b11;
        #1;
        chk("rst_ready", 32'(pif.ready), 32'd0);
        chk("rst_taken", 32'(pif.pred_taken), 32'd0);
        chk("rst_hist", 32'(pif.pred_hist), 32'd0);
        chk("rst_drop", 32'(pif.drop_cnt), 32'd0);
        n = 1;
        while (!pif.ready && n < 40) begin
            step();
            #1;
            n++;
        end
        chk("init_len", n, 32'd17);
        chk("init_ctr", 32'(pif.pred_ctr), 32'hA);
        chk("init_taken", 32'(pif.pred_taken), 32'h3);
        for (int k = 0; k < 8; k++) begin
            pif.lookup_pc = 32'(k * 8);
            step();
            #1;
            chk("init_sweep", 32'(pif.pred_ctr), 32'hA);
        end
        // training entry 0 towards strongly not-taken
        pif.btb_hit = 2'b00;
        pif.lookup_pc = 32'h100;
        set_upd(0, 32'h100, 12'h0, 2'd2, 1'b0, 1'b0, 1'b0);
        step();
        set_upd(0, 32'h100, 12'h0, 2'd1, 1'b0, 1'b0, 1'b0);
        #1;
        chk("train_nobypass", 32'(pif.pred_ctr[1:0]), 32'd2);
        step();
        set_upd(0, 32'h100, 12'h0, 2'd0, 1'b0, 1'b0, 1'b0);
        #1;
        chk("train_1", 32'(pif.pred_ctr[1:0]), 32'd1);
        step();
        clr_upd();
        pif.btb_hit = 2'b11;
        #1;
        chk("train_0", 32'(pif.pred_ctr[1:0]), 32'd0);
        step();
        #1;
        chk("train_sat", 32'(pif.pred_ctr), 32'h8);
        chk("train_taken", 32'(pif.pred_taken), 32'h2);
        // history shift: NT then T from 0b101
        pif.btb_hit = 2'b00;
        pif.lookup_pc = 32'h14;
        set_upd(0, 32'h100, 12'h5, 2'd2, 1'b1, 1'b1, 1'b0);
        step();
        clr_upd();
        pif.btb_hit = 2'b11;
        pif.is_cond = 2'b11;
        #1;
        chk("hs_hist0", 32'(pif.pred_hist), 32'h5);
        chk("hs_ctr", 32'(pif.pred_ctr), 32'h8);
        chk("hs_taken", 32'(pif.pred_taken), 32'h2);
        step();
        pif.btb_hit = 2'b00;
        pif.is_cond = 2'b00;
        #1;
        chk("hs_nt_t", 32'(pif.pred_hist), 32'h15);
        // history shift: slot0 taken stops the walk
        pif.lookup_pc = 32'h18;
        set_upd(0, 32'h100, 12'h5, 2'd2, 1'b1, 1'b1, 1'b0);
        step();
        clr_upd();
        pif.btb_hit = 2'b11;
        pif.is_cond = 2'b11;
        #1;
        chk("hs2_taken", 32'(pif.pred_taken), 32'h3);
        chk("hs2_hist0", 32'(pif.pred_hist), 32'h5);
        step();
        pif.btb_hit = 2'b00;
        pif.is_cond = 2'b00;
        #1;
        chk("hs_t_first", 32'(pif.pred_hist), 32'hB);
        // recovery while stalled
        pif.stall = 1'b1;
        set_upd(0, 32'h200, 12'h0, 2'd2, 1'b1, 1'b0, 1'b1);
        set_upd(1, 32'h200, 12'h3, 2'd2, 1'b1, 1'b1, 1'b1);
        step();
        set_upd(0, 32'h200, 12'h10, 2'd2, 1'b1, 1'b1, 1'b0);
        set_upd(1, 32'h200, 12'h3, 2'd2, 1'b1, 1'b1, 1'b1);
        #1;
        chk("rec_port1", 32'(pif.pred_hist), 32'h7);
        step();
        clr_upd();
        pif.btb_hit = 2'b11;
        pif.is_cond = 2'b11;
        #1;
        chk("rec_port0", 32'(pif.pred_hist), 32'h10);
        step();
        #1;
        chk("stall_noshift", 32'(pif.pred_hist), 32'h10);
        chk("stall_drop", 32'(pif.drop_cnt), 32'd0);
        pif.stall = 1'b0;
        pif.btb_hit = 2'b00;
        pif.is_cond = 2'b00;
        pif.lookup_pc = 32'h200;
        step();
        step();
        // overflow: all six updates target entry 1, slot 0 watches it
        set_upd(0, 32'h200, 12'h10, 2'd1, 1'b0, 1'b0, 1'b1);
        set_upd(1, 32'h200, 12'h10, 2'd0, 1'b1, 1'b0, 1'b1);
        step();
        set_upd(0, 32'h200, 12'h10, 2'd1, 1'b1, 1'b0, 1'b1);
        set_upd(1, 32'h200, 12'h10, 2'd2, 1'b1, 1'b0, 1'b1);
        step();
        set_upd(0, 32'h200, 12'h10, 2'd0, 1'b1, 1'b0, 1'b1);
        set_upd(1, 32'h200, 12'h10, 2'd0, 1'b0, 1'b0, 1'b1);
        #1;
        chk("ovf_w0", 32'(pif.pred_ctr[1:0]), 32'd0);
        step();
        clr_upd();
        #1;
        chk("ovf_w1", 32'(pif.pred_ctr[1:0]), 32'd1);
        chk("ovf_drop", 32'(pif.drop_cnt), 32'd1);
        step();
        #1;
        chk("ovf_w2", 32'(pif.pred_ctr[1:0]), 32'd2);
        step();
        #1;
        chk("ovf_w3", 32'(pif.pred_ctr[1:0]), 32'd3);
        step();
        #1;
        chk("ovf_w4", 32'(pif.pred_ctr[1:0]), 32'd1);
        step();
        #1;
        chk("ovf_final", 32'(pif.pred_ctr[1:0]), 32'd1);
        // folding: hist 0xABC with pc index 0 lands on entry 0xD
        pif.lookup_pc = 32'h0;
        set_upd(0, 32'h0, 12'hABC, 2'd2, 1'b0, 1'b1, 1'b0);
        step();
        clr_upd();
        #1;
        chk("fold_hist", 32'(pif.pred_hist), 32'hABC);
        chk("fold_old", 32'(pif.pred_ctr), 32'hA);
        step();
        #1;
        chk("fold_new", 32'(pif.pred_ctr[1:0]), 32'd1);
        pif.lookup_pc = 32'h34;
        set_upd(0, 32'h3C, 12'h0, 2'd0, 1'b0, 1'b1, 1'b0);
        step();
        clr_upd();
        #1;
        chk("fold_abs", 32'(pif.pred_ctr), 32'h9);
        chk("fold_hist0", 32'(pif.pred_hist), 32'h0);
        // reset again after activity
        rst = 1'b1;
        pif.btb_hit = 2'b11;
        step();
        #1;
        chk("rst2_ready", 32'(pif.ready), 32'd0);
        chk("rst2_drop", 32'(pif.drop_cnt), 32'd0);
        chk("rst2_taken", 32'(pif.pred_taken), 32'd0);
        rst = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule
